hart_pattern_gen: RTL and testbench
===================================

Name: hart_pattern_gen

Overview:
- Heart-rate sample generator: the transmitting end of the 6-bit `hart` sample bus that the stress/heart detectors consume.
- Accepts a target heart rate over a valid/ready handshake.
- Ramps `hart` toward the target in bounded steps, one step per sample strobe, then holds the value for a programmable number of samples.
- Used as the on-chip stimulus source for the input-side detectors and for demo patterns.

Parameters:
- RESET_HART, 50: value driven on `hart` after reset.
- MIN_HART, 20: lower clamp applied to any accepted target.
- MAX_HART, 63: upper clamp applied to any accepted target.
- HOLD_SAMPLES, 3: number of sample strobes `hart` must stay unchanged at the target before `stable` asserts. Default matches the 4-equal-sample window of the detectors.

Ports:
- slow  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (low = reset).
- sample_en  in  1  sample strobe; ramp and hold counters advance only on cycles where it is high.
- tgt_valid  in  1  a new target is offered.
- tgt_ready  out  1  generator can accept a target.
- tgt_hart  in  6  offered target heart rate.
- tgt_step  in  3  ramp step size per sample, latched with the target; 0 is treated as 1.
- hart  out  6  current heart-rate sample.
- rising  out  1  high while ramping up.
- falling  out  1  high while ramping down.
- stable  out  1  high once the hold count is complete.

Behaviour:
- Reset (reset==0 at the edge):
  - state=IDLE, hart=RESET_HART, step latch=1, hold counter=0.
  - rising=0, falling=0, stable=0, tgt_ready=1.
  - Reset applies mid-ramp or mid-handshake; any offered target on that edge is dropped.
- States: IDLE, RAMP_UP, RAMP_DOWN, HOLD.
- tgt_ready is combinational: 1 in IDLE and HOLD, 0 in RAMP_UP and RAMP_DOWN.
- Accept occurs when tgt_valid & tgt_ready at the edge, independent of sample_en.
  - Target latched as clamp(tgt_hart, MIN_HART, MAX_HART); step latched as max(tgt_step, 1).
  - Hold counter cleared; stable goes to 0 on that same edge.
  - Next state: latched target > hart → RAMP_UP; latched target < hart → RAMP_DOWN; equal → HOLD.
  - `hart` does not change on the accept edge (first step follows on a later sample_en edge).
- RAMP_UP, on a sample_en edge:
  - If target − hart ≤ step: hart=target, go to HOLD, hold counter=0.
  - Otherwise hart += step.
  - Arithmetic uses 7-bit intermediates; the 6-bit result never wraps.
- RAMP_DOWN: mirror of RAMP_UP (hart −= step, landing exactly on target; no underflow).
- HOLD, on a sample_en edge:
  - If counter < HOLD_SAMPLES, counter += 1.
  - stable = (counter == HOLD_SAMPLES), registered, and stays high until the next accept or reset.
- IDLE: hart is held; stable=0.
- Flags: rising = (state==RAMP_UP) and falling = (state==RAMP_DOWN), both registered with the state.
- sample_en low freezes hart and the counters in every state.
- An accept in HOLD restarts a ramp from the current hart. An accept with a target equal to hart re-enters HOLD and restarts the count.
- hart changes by at most the latched step per sample. It never overshoots the target and never leaves [0,63].

Decomposition:
- Shared package holds:
  - state encoding for IDLE/RAMP_UP/RAMP_DOWN/HOLD;
  - HART_W=6 and STEP_W=3;
  - RESET_HART/MIN_HART/MAX_HART defaults, shared with the detectors so reset conventions stay aligned.
- One natural sub-module, hart_step_unit: combinational saturating step-toward-target (current, target, step → next, arrived).
- FSM, handshake and hold counter stay in the top.

Test Plan:
- Reset: hold reset low 2 cycles → hart=50, tgt_ready=1, stable=0, rising=falling=0; hart stays 50 with sample_en=1 and no target.
- Ramp up, coarse step: accept target 60, step 4, from 50, sample_en every cycle → hart 54, 58, 60; rising high 3 samples; tgt_ready=0 until the edge hart=60 lands; stable=1 after 3 further samples.
- Ramp down, clamp: accept target 5, step 7, from 50 → clamped to 20; hart 43, 36, 29, 22, 20; falling high throughout; no underflow.
- Equal target and step 0: accept target 50, step 0 → direct HOLD, hart constant; stable after exactly 3 sample_en pulses; sample_en low gaps delay stable accordingly.
- Re-target in HOLD: stable=1 at 60, accept 40 step 3 → stable drops on the accept edge; hart 57, 54 … 42, 40; tgt_valid held during the ramp is not accepted until HOLD.
- Reset mid-ramp: assert reset while hart=56 ramping to 60 → next edge hart=50, IDLE, flags cleared; a tgt_valid on the reset edge is ignored.

Source files
------------

// File: rtl/hart_pattern_gen_pkg.sv
// Shared definitions for the hart sample bus: widths, reset/clamp defaults, generator states.
package hart_pattern_gen_pkg;

  localparam int unsigned HART_W = 6;
  localparam int unsigned STEP_W = 3;

  // Defaults shared with the stress/heart detectors so reset values stay aligned.
  localparam int unsigned DEF_RESET_HART   = 50;
  localparam int unsigned DEF_MIN_HART     = 20;
  localparam int unsigned DEF_MAX_HART     = 63;
  localparam int unsigned DEF_HOLD_SAMPLES = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } hart_state_e;

  function automatic logic [HART_W-1:0] clamp_hart(input logic [HART_W-1:0] v,
                                                   input int unsigned lo,
                                                   input int unsigned hi);
    logic [HART_W-1:0] r;
    r = v;
    if (v < HART_W'(lo)) r = HART_W'(lo);
    else if (v > HART_W'(hi)) r = HART_W'(hi);
    return r;
  endfunction

endpackage

// File: rtl/hart_pattern_gen_step.sv
// Saturating single step of cur toward tgt by at most step; lands exactly on tgt.
module hart_step_unit
  import hart_pattern_gen_pkg::*;
(
  input  logic [HART_W-1:0] cur,
  input  logic [HART_W-1:0] tgt,
  input  logic [STEP_W-1:0] step,
  output logic [HART_W-1:0] nxt,
  output logic              arrived
);

  localparam int unsigned EXT_W = HART_W + 1;

  logic [EXT_W-1:0] diff;

  always_comb begin
    nxt     = cur;
    arrived = 1'b0;
    if (tgt >= cur) diff = {1'b0, tgt} - {1'b0, cur};
    else            diff = {1'b0, cur} - {1'b0, tgt};

    // Within one step of the target: snap to it instead of overshooting.
    if (diff <= EXT_W'(step)) begin
      nxt     = tgt;
      arrived = 1'b1;
    end else if (tgt > cur) begin
      nxt = HART_W'({1'b0, cur} + EXT_W'(step));
    end else begin
      nxt = HART_W'({1'b0, cur} - EXT_W'(step));
    end
  end

endmodule

// File: rtl/hart_pattern_gen.sv
// Heart-rate sample generator: accepts a target, ramps hart toward it per sample strobe, then holds.
module hart_pattern_gen
  import hart_pattern_gen_pkg::*;
#(
  parameter int unsigned RESET_HART   = DEF_RESET_HART,
  parameter int unsigned MIN_HART     = DEF_MIN_HART,
  parameter int unsigned MAX_HART     = DEF_MAX_HART,
  parameter int unsigned HOLD_SAMPLES = DEF_HOLD_SAMPLES
)(
  input  logic              slow,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [HART_W-1:0] tgt_hart,
  input  logic [STEP_W-1:0] tgt_step,
  output logic [HART_W-1:0] hart,
  output logic              rising,
  output logic              falling,
  output logic              stable
);

  localparam int unsigned CNT_W = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

  hart_state_e       state_q, state_d;
  logic [HART_W-1:0] hart_q, hart_d;
  logic [HART_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic              rising_q, falling_q;

  logic [HART_W-1:0] clamped;
  logic [HART_W-1:0] step_nxt;
  logic              step_arrived;
  logic              accept;

  assign tgt_ready = (state_q == IDLE) || (state_q == HOLD);
  assign accept    = tgt_valid && tgt_ready;
  assign clamped   = clamp_hart(tgt_hart, MIN_HART, MAX_HART);

  hart_step_unit u_step (
    .cur     (hart_q),
    .tgt     (tgt_q),
    .step    (step_q),
    .nxt     (step_nxt),
    .arrived (step_arrived)
  );

  always_ff @(posedge slow) begin
    if (!reset) begin
      state_q   <= IDLE;
      hart_q    <= HART_W'(RESET_HART);
      tgt_q     <= HART_W'(RESET_HART);
      step_q    <= STEP_W'(1);
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      rising_q  <= 1'b0;
      falling_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hart_q    <= hart_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rising_q  <= (state_d == RAMP_UP);
      falling_q <= (state_d == RAMP_DOWN);
    end
  end

  always_comb begin
    state_d  = state_q;
    hart_d   = hart_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;

    // Accept takes priority and never moves hart; stepping starts on a later strobe.
    if (accept) begin
      tgt_d    = clamped;
      step_d   = (tgt_step == '0) ? STEP_W'(1) : tgt_step;
      cnt_d    = '0;
      stable_d = 1'b0;
      if (clamped > hart_q)      state_d = RAMP_UP;
      else if (clamped < hart_q) state_d = RAMP_DOWN;
      else                       state_d = HOLD;
    end else begin
      unique case (state_q)
        IDLE: stable_d = 1'b0;
        RAMP_UP, RAMP_DOWN: begin
          if (sample_en) begin
            hart_d = step_nxt;
            if (step_arrived) begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end
        end
        HOLD: begin
          if (sample_en) begin
            if (cnt_q < CNT_W'(HOLD_SAMPLES)) cnt_d = cnt_q + CNT_W'(1);
            stable_d = (cnt_d == CNT_W'(HOLD_SAMPLES));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign hart    = hart_q;
  assign rising  = rising_q;
  assign falling = falling_q;
  assign stable  = stable_q;

endmodule

// File: tb/tb_hart_pattern_gen.sv
// Directed table-driven bench for hart_pattern_gen plus hand-written reset and wait sequences.
module tb_hart_pattern_gen;

  logic       slow;
  logic       reset;
  logic       sample_en;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [5:0] tgt_hart;
  logic [2:0] tgt_step;
  logic [5:0] hart;
  logic       rising;
  logic       falling;
  logic       stable;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       se;
    logic       tv;
    logic [5:0] th;
    logic [2:0] ts;
    logic [5:0] e_hart;
    logic       e_rdy;
    logic       e_rise;
    logic       e_fall;
    logic       e_stab;
  } vec_t;

  vec_t vecs[$];

  hart_pattern_gen dut (
    .slow      (slow),
    .reset     (reset),
    .sample_en (sample_en),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_hart  (tgt_hart),
    .tgt_step  (tgt_step),
    .hart      (hart),
    .rising    (rising),
    .falling   (falling),
    .stable    (stable)
  );

  initial slow = 1'b0;
  always #5 slow = ~slow;

  task automatic add(input logic se, input logic tv, input logic [5:0] th, input logic [2:0] ts,
                     input logic [5:0] eh, input logic er, input logic eu, input logic ed,
                     input logic es);
    vec_t v;
    v.se = se; v.tv = tv; v.th = th; v.ts = ts;
    v.e_hart = eh; v.e_rdy = er; v.e_rise = eu; v.e_fall = ed; v.e_stab = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic cyc(input logic rst, input logic se, input logic tv,
                     input logic [5:0] th, input logic [2:0] ts);
    reset = rst; sample_en = se; tgt_valid = tv; tgt_hart = th; tgt_step = ts;
    @(posedge slow);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [5:0] eh, input logic er,
                         input logic eu, input logic ed, input logic es);
    chk({tag, ".hart"},    idx, int'(hart),      int'(eh));
    chk({tag, ".ready"},   idx, int'(tgt_ready), int'(er));
    chk({tag, ".rising"},  idx, int'(rising),    int'(eu));
    chk({tag, ".falling"}, idx, int'(falling),   int'(ed));
    chk({tag, ".stable"},  idx, int'(stable),    int'(es));
  endtask

  initial begin
    int n;
    reset = 1'b0; sample_en = 1'b0; tgt_valid = 1'b0; tgt_hart = '0; tgt_step = '0;

    //   se tv th  ts  hart rdy rise fall stab
    add(1, 0,  0, 0,  50, 1, 0, 0, 0);  // idle holds reset value
    add(1, 1, 50, 0,  50, 1, 0, 0, 0);  // equal target, step 0 -> HOLD
    add(1, 0,  0, 0,  50, 1, 0, 0, 0);
    add(0, 0,  0, 0,  50, 1, 0, 0, 0);
    add(1, 0,  0, 0,  50, 1, 0, 0, 0);
    add(0, 0,  0, 0,  50, 1, 0, 0, 0);
    add(1, 0,  0, 0,  50, 1, 0, 0, 1);  // third strobe
    add(1, 1, 60, 4,  50, 0, 1, 0, 0);  // ramp up, coarse step
    add(1, 0,  0, 0,  54, 0, 1, 0, 0);
    add(1, 0,  0, 0,  58, 0, 1, 0, 0);
    add(1, 0,  0, 0,  60, 1, 0, 0, 0);
    add(1, 0,  0, 0,  60, 1, 0, 0, 0);
    add(1, 0,  0, 0,  60, 1, 0, 0, 0);
    add(1, 0,  0, 0,  60, 1, 0, 0, 1);
    add(0, 0,  0, 0,  60, 1, 0, 0, 1);
    add(1, 1, 40, 3,  60, 0, 0, 1, 0);  // retarget from HOLD
    add(1, 1, 10, 1,  57, 0, 0, 1, 0);  // valid during ramp ignored
    add(1, 1, 10, 1,  54, 0, 0, 1, 0);
    add(0, 1, 10, 1,  54, 0, 0, 1, 0);  // strobe low freezes
    add(1, 0,  0, 0,  51, 0, 0, 1, 0);
    add(1, 0,  0, 0,  48, 0, 0, 1, 0);
    add(1, 0,  0, 0,  45, 0, 0, 1, 0);
    add(1, 0,  0, 0,  42, 0, 0, 1, 0);
    add(1, 0,  0, 0,  40, 1, 0, 0, 0);
    add(1, 1,  5, 7,  40, 0, 0, 1, 0);  // target clamped up to 20
    add(1, 0,  0, 0,  33, 0, 0, 1, 0);
    add(1, 0,  0, 0,  26, 0, 0, 1, 0);
    add(1, 0,  0, 0,  20, 1, 0, 0, 0);
    add(1, 1, 22, 0,  20, 0, 1, 0, 0);  // step 0 ramps by 1
    add(1, 0,  0, 0,  21, 0, 1, 0, 0);
    add(1, 0,  0, 0,  22, 1, 0, 0, 0);
    add(1, 1, 63, 7,  22, 0, 1, 0, 0);  // ramp to top of range
    add(1, 0,  0, 0,  29, 0, 1, 0, 0);
    add(1, 0,  0, 0,  36, 0, 1, 0, 0);
    add(1, 0,  0, 0,  43, 0, 1, 0, 0);
    add(1, 0,  0, 0,  50, 0, 1, 0, 0);
    add(1, 0,  0, 0,  57, 0, 1, 0, 0);
    add(1, 0,  0, 0,  63, 1, 0, 0, 0);
    add(1, 1, 63, 5,  63, 1, 0, 0, 0);  // equal target re-enters HOLD

    // Reset held two cycles.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk_all("reset", 0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(1, vecs[i].se, vecs[i].tv, vecs[i].th, vecs[i].ts);
      chk_all("vec", i, vecs[i].e_hart, vecs[i].e_rdy, vecs[i].e_rise, vecs[i].e_fall,
              vecs[i].e_stab);
    end

    // Reset mid-ramp with a target offered on the reset edge.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 6'd60, 3'd6);
    chk_all("midramp.accept", 0, 6'd50, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk_all("midramp.step", 0, 6'd56, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1, 1, 6'd30, 3'd1);
    chk_all("midramp.reset", 0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1, 1, 0, 0, 0);
    chk_all("midramp.idle", 0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bounded wait for stable: accept edge, two ramp strobes, three hold strobes.
    cyc(1, 1, 1, 6'd53, 3'd2);
    n = 1;
    while (!stable && n < 20) begin
      cyc(1, 1, 0, 0, 0);
      n++;
    end
    chk("wait.cycles", 0, n, 6);
    chk("wait.hart", 0, int'(hart), 53);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
